// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared constants and types for the MIPS IF/ID pipeline slice
// Purpose: opcode constants, the NOP word, the IF/ID FSM state type and the
//          uses_rt() helper shared by the IF/ID register and hazard logic.
// Ports:   none (package).
package mips_pipe_pkg;

  localparam logic [5:0]  OP_RTYPE = 6'h00;
  localparam logic [5:0]  OP_BEQ   = 6'h04;
  localparam logic [5:0]  OP_BNE   = 6'h05;
  localparam logic [5:0]  OP_SW    = 6'h2B;
  localparam logic [5:0]  OP_LW    = 6'h23;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } if_id_state_e;

  // rt is read as a source only by R-type, branches and stores; for every
  // other opcode (lw, immediates) rt names the destination.
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
           (opcode == OP_BNE)   || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare
// Purpose: flags a load in EX whose destination is read by the instruction in ID.
// Ports:
//   valid_i       instruction in ID is real
//   ex_memread_i  ID/EX holds a load
//   ex_rt_i       load destination register
//   opcode_i      opcode of the ID instruction
//   rs_i, rt_i    source fields of the ID instruction
//   hazard_o      load-use hazard present
module hazard_detect
  import mips_pipe_pkg::*;
(
  input  logic       valid_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rt_i,
  input  logic [5:0] opcode_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  output logic       hazard_o
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rt_i == rs_i);
  assign rt_match = uses_rt(opcode_i) && (ex_rt_i == rt_i);

  // $0 is hardwired, so a load targeting it never creates a dependency.
  assign hazard_o = valid_i && ex_memread_i && (ex_rt_i != 5'd0) &&
                    (rs_match || rt_match);

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with load-use stall and branch flush
// Purpose: latches fetched instruction and PC+4, presents decode fields, stalls
//          one cycle on a load-use hazard and flushes on a taken branch.
//          Optional perf counters built when IF_ID_PERF_CNT_EN is defined.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   pc_plus4_in, instr_in  fetch outputs; imem_valid qualifies instr_in
//   branch_taken           flush IF/ID
//   ex_memread, ex_rt      load in EX and its destination
//   pc_plus4_out, instr_out, valid_out   latched fetch data
//   rs_out, rt_out, rd_out               register fields of instr_out
//   pc_write, id_ex_bubble               stall controls
//   stall_cnt, flush_cnt                 perf counters (0 when disabled)
module if_id_stage
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_WORD,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_plus4_in,
  input  logic [31:0]      instr_in,
  input  logic             imem_valid,
  input  logic             branch_taken,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  output logic [31:0]      pc_plus4_out,
  output logic [31:0]      instr_out,
  output logic             valid_out,
  output logic [4:0]       rs_out,
  output logic [4:0]       rt_out,
  output logic [4:0]       rd_out,
  output logic             pc_write,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  if_id_state_e state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic         hazard;
  logic         stall;

  hazard_detect u_hazard (
    .valid_i      (valid_q),
    .ex_memread_i (ex_memread),
    .ex_rt_i      (ex_rt),
    .opcode_i     (instr_q[31:26]),
    .rs_i         (instr_q[25:21]),
    .rt_i         (instr_q[20:16]),
    .hazard_o     (hazard)
  );

  // In STALL the load has moved on, so a hazard seen there is stale.
  assign stall = (state_q == RUN) && hazard && !branch_taken;

  always_comb begin
    state_d = RUN;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (branch_taken) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      pc_d    = pc_plus4_in;
    end else if (stall) begin
      state_d = STALL;
    end else if (imem_valid) begin
      instr_d = instr_in;
      valid_d = 1'b1;
      pc_d    = pc_plus4_in;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      pc_d    = pc_plus4_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      instr_q <= NOP_INSTR;
      pc_q    <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign pc_plus4_out = pc_q;
  assign instr_out    = instr_q;
  assign valid_out    = valid_q;
  assign rs_out       = instr_q[25:21];
  assign rt_out       = instr_q[20:16];
  assign rd_out       = instr_q[15:11];
  assign pc_write     = !stall;
  assign id_ex_bubble = stall;

`ifdef IF_ID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Counters saturate rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (branch_taken && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed self-checking bench for if_id_stage
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_plus4_in;
  logic [31:0] instr_in;
  logic        imem_valid;
  logic        branch_taken;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic [31:0] pc_plus4_out;
  logic [31:0] instr_out;
  logic        valid_out;
  logic [4:0]  rs_out, rt_out, rd_out;
  logic        pc_write;
  logic        id_ex_bubble;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_stage #(.NOP_INSTR(32'h0000_0000), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_plus4_in  (pc_plus4_in),
    .instr_in     (instr_in),
    .imem_valid   (imem_valid),
    .branch_taken (branch_taken),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .pc_plus4_out (pc_plus4_out),
    .instr_out    (instr_out),
    .valid_out    (valid_out),
    .rs_out       (rs_out),
    .rt_out       (rt_out),
    .rd_out       (rd_out),
    .pc_write     (pc_write),
    .id_ex_bubble (id_ex_bubble),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    imem_valid  = v;
    instr_in    = ins;
    pc_plus4_in = pc;
  endtask

  initial begin
    int exp_stalls;
    int exp_flushes;
`ifdef IF_ID_PERF_CNT_EN
    exp_stalls  = 3;
    exp_flushes = 2;
`else
    exp_stalls  = 0;
    exp_flushes = 0;
`endif
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    branch_taken = 1'b0;
    ex_memread   = 1'b0;
    ex_rt        = 5'd0;
    #3;
    check("rst_pc",     pc_plus4_out, 32'h0);
    check("rst_instr",  instr_out,    32'h0);
    check("rst_valid",  {31'd0, valid_out},    32'd0);
    check("rst_pcw",    {31'd0, pc_write},     32'd1);
    check("rst_bubble", {31'd0, id_ex_bubble}, 32'd0);
    check("rst_scnt",   stall_cnt, 32'd0);
    check("rst_fcnt",   flush_cnt, 32'd0);
    tick();
    reset = 1'b0;

    // 1: plain load of add $8,$9,$10
    drive(1'b1, 32'h012A4020, 32'd4);
    tick();
    check("t1_instr", instr_out, 32'h012A4020);
    check("t1_valid", {31'd0, valid_out}, 32'd1);
    check("t1_pc",    pc_plus4_out, 32'd4);
    check("t1_rs",    {27'd0, rs_out}, 32'd9);
    check("t1_rt",    {27'd0, rt_out}, 32'd10);
    check("t1_rd",    {27'd0, rd_out}, 32'd8);
    check("t1_pcw",   {31'd0, pc_write}, 32'd1);

    // 2: load-use on rs, exactly one stall cycle
    drive(1'b1, 32'h01095020, 32'd8);
    tick();
    ex_memread = 1'b1;
    ex_rt      = 5'd8;
    drive(1'b1, 32'h8D090000, 32'd12);
    #1;
    check("t2_pcw0",    {31'd0, pc_write}, 32'd0);
    check("t2_bubble1", {31'd0, id_ex_bubble}, 32'd1);
    tick();
    check("t2_hold_instr", instr_out, 32'h01095020);
    check("t2_hold_pc",    pc_plus4_out, 32'd8);
    check("t2_pcw_again",  {31'd0, pc_write}, 32'd1);
    check("t2_bubble0",    {31'd0, id_ex_bubble}, 32'd0);
    tick();
    check("t2_next_instr", instr_out, 32'h8D090000);
    check("t2_next_pc",    pc_plus4_out, 32'd12);

    // 3: lw rt is a destination, $0 never hazards, sw reads rt
    ex_rt = 5'd9;
    #1;
    check("t3_lw_rt", {31'd0, pc_write}, 32'd1);
    drive(1'b1, 32'h00004020, 32'd16);
    ex_rt = 5'd0;
    tick();
    check("t3_rs0_instr", instr_out, 32'h00004020);
    check("t3_rt_zero",   {31'd0, pc_write}, 32'd1);
    drive(1'b1, 32'hAD090000, 32'd20);
    tick();
    ex_rt = 5'd9;
    #1;
    check("t3_sw_pcw",    {31'd0, pc_write}, 32'd0);
    check("t3_sw_bubble", {31'd0, id_ex_bubble}, 32'd1);
    drive(1'b1, 32'h01095020, 32'd24);
    tick();
    check("t3_sw_hold", instr_out, 32'hAD090000);
    check("t3_stall_ignore", {31'd0, pc_write}, 32'd1);
    tick();
    check("t3_rtype_in", instr_out, 32'h01095020);

    // 4: flush overrides a present hazard (R-type reads rt=$9)
    check("t4_haz_pcw", {31'd0, pc_write}, 32'd0);
    branch_taken = 1'b1;
    drive(1'b1, 32'h012A4020, 32'h40);
    #1;
    check("t4_flush_pcw",    {31'd0, pc_write}, 32'd1);
    check("t4_flush_bubble", {31'd0, id_ex_bubble}, 32'd0);
    tick();
    branch_taken = 1'b0;
    check("t4_instr", instr_out, 32'h0);
    check("t4_valid", {31'd0, valid_out}, 32'd0);
    check("t4_pc",    pc_plus4_out, 32'h40);
    check("t4_pcw",   {31'd0, pc_write}, 32'd1);
    // state returned to RUN: a fresh hazard stalls again
    drive(1'b1, 32'h01095020, 32'h44);
    tick();
    check("t4_run_stall", {31'd0, pc_write}, 32'd0);
    tick();
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    check("t4_stall_flush_instr", instr_out, 32'h0);
    check("t4_stall_flush_valid", {31'd0, valid_out}, 32'd0);

    // 5: imem_valid low inserts a NOP, no hazard on its zero fields
    drive(1'b0, 32'h01095020, 32'h50);
    ex_rt = 5'd0;
    tick();
    check("t5_instr", instr_out, 32'h0);
    check("t5_valid", {31'd0, valid_out}, 32'd0);
    check("t5_pc",    pc_plus4_out, 32'h50);
    check("t5_rs",    {27'd0, rs_out}, 32'd0);
    check("t5_pcw",   {31'd0, pc_write}, 32'd1);

    // 6: counters, then reset in the middle of a stall
    check("t6_scnt", stall_cnt, exp_stalls);
    check("t6_fcnt", flush_cnt, exp_flushes);
    drive(1'b1, 32'h01095020, 32'h60);
    ex_rt = 5'd8;
    tick();
    check("t6_pre_pcw", {31'd0, pc_write}, 32'd0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_scnt",  stall_cnt, 32'd0);
    check("t6_rst_fcnt",  flush_cnt, 32'd0);
    check("t6_rst_pcw",   {31'd0, pc_write}, 32'd1);
    check("t6_rst_instr", instr_out, 32'h0);
    check("t6_rst_valid", {31'd0, valid_out}, 32'd0);
    check("t6_rst_bub",   {31'd0, id_ex_bubble}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t6_post_instr", instr_out, 32'h01095020);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
